// File: rtl/bus_demux_pkg.sv
// Shared types and constants for the bus write demux / register bank.
package bus_demux_pkg;

   localparam int REG_COUNT = 8;
   localparam int KEY_W     = 3;

   // Transaction sequencing: IDLE takes the first beat, BURST takes the
   // rest, DONE is the one-cycle completion pulse.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/bus_demux_regbank_dec3x8.sv
// 3-to-8 one-hot decoder: turns a register index plus an accept strobe
// into per-register load enables (all zero when the strobe is low).
module dec3x8
   import bus_demux_pkg::*;
(
   input  logic [KEY_W-1:0]     idx_i,
   input  logic                 en_i,
   output logic [REG_COUNT-1:0] onehot_o
);

   // Raise exactly one enable for the selected register when strobed.
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/bus_demux_regbank.sv
// Write-side demux into eight W-bit holding registers r0..r7.
// Single-beat and auto-incrementing (wrapping) burst writes.
// Handshake: a beat is consumed on every rising edge where
// wr_valid && wr_ready; din/key/burst_len are only looked at on such edges.
// Optional macro BUS_DEMUX_R7_PROTECT_EN: beats aimed at r7 are accepted
// and counted but r7 is never loaded (reset still clears it).
module bus_demux_regbank
   import bus_demux_pkg::*;
#(
   parameter int W = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [W-1:0]     din,
   input  logic [KEY_W-1:0] key,
   input  logic [2:0]       burst_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic             wr_done,
   output logic             busy,
   output logic [W-1:0]     r0,
   output logic [W-1:0]     r1,
   output logic [W-1:0]     r2,
   output logic [W-1:0]     r3,
   output logic [W-1:0]     r4,
   output logic [W-1:0]     r5,
   output logic [W-1:0]     r6,
   output logic [W-1:0]     r7,
   output logic [1:0]       state_dbg_o
);

   state_e                 state_q, state_d;
   logic [KEY_W-1:0]       ptr_q, ptr_d;
   logic [2:0]             rem_q, rem_d;
   logic [W-1:0]           regs_q [REG_COUNT];
   logic [W-1:0]           regs_d [REG_COUNT];
   logic                   accept;
   logic [KEY_W-1:0]       sel_idx;
   logic [REG_COUNT-1:0]   dec_en;
   logic [REG_COUNT-1:0]   load_en;

   assign wr_ready    = (state_q != DONE);
   assign busy        = (state_q != IDLE);
   assign wr_done     = (state_q == DONE);
   assign accept      = wr_valid && wr_ready;
   assign state_dbg_o = state_q;

   // The first beat is addressed by key, later beats by the running pointer.
   assign sel_idx = (state_q == IDLE) ? key : ptr_q;

   dec3x8 u_dec (
      .idx_i    (sel_idx),
      .en_i     (accept),
      .onehot_o (dec_en)
   );

`ifdef BUS_DEMUX_R7_PROTECT_EN
   assign load_en = {1'b0, dec_en[REG_COUNT-2:0]};
`else
   assign load_en = dec_en;
`endif

   // Next register-file contents: only the enabled register takes din.
   always_comb begin
      for (int i = 0; i < REG_COUNT; i++) begin
         regs_d[i] = load_en[i] ? din : regs_q[i];
      end
   end

   // Register file; outputs come straight from these flops.
   always_ff @(posedge Clock) begin
      for (int i = 0; i < REG_COUNT; i++) begin
         if (Reset) regs_q[i] <= '0;
         else       regs_q[i] <= regs_d[i];
      end
   end

   assign r0 = regs_q[0];
   assign r1 = regs_q[1];
   assign r2 = regs_q[2];
   assign r3 = regs_q[3];
   assign r4 = regs_q[4];
   assign r5 = regs_q[5];
   assign r6 = regs_q[6];
   assign r7 = regs_q[7];

   // Sequencer next state: pointer and remaining-beat count advance per accept.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (burst_len == 3'd0) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = key + 3'd1;
                  rem_d   = burst_len - 3'd1;
                  state_d = BURST;
               end
            end
         end
         BURST: begin
            if (accept) begin
               ptr_d = ptr_q + 3'd1;
               if (rem_q == 3'd0) state_d = DONE;
               else               rem_d   = rem_q - 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer state; reset aborts any burst without a completion pulse.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
      end
   end

endmodule

// File: tb/tb_bus_demux_regbank.sv
// Bench for bus_demux_regbank: directed scenarios plus random transactions,
// checked against an array model of the register file and a done-queue
// scoreboard. Honours BUS_DEMUX_R7_PROTECT_EN when defined.
module tb_bus_demux_regbank;
  import bus_demux_pkg::*;

  localparam int W = 16;

`ifdef BUS_DEMUX_R7_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] din = '0;
  logic [2:0]   key = '0;
  logic [2:0]   burst_len = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready, wr_done, busy;
  logic [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [1:0]   state_dbg;

  always #5 Clock = ~Clock;

  bus_demux_regbank #(.W(W)) dut (
    .Clock(Clock), .Reset(Reset), .din(din), .key(key),
    .burst_len(burst_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_done(wr_done), .busy(busy),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .state_dbg_o(state_dbg)
  );

  // ---------------- model and scoreboard ----------------
  logic [W-1:0]   model [8];
  logic [8*W-1:0] exp_q [$];
  logic [8*W-1:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [8*W-1:0] dut_regs();
    return {r7, r6, r5, r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [8*W-1:0] model_regs();
    logic [8*W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*W +: W] = model[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  task automatic model_write(input logic [2:0] k, input logic [W-1:0] d);
    if (!(PROT && k == 3'd7)) model[k] = d;
  endtask

  task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every completion pulse must match the oldest expected snapshot.
  always @(negedge Clock) begin
    if (!Reset && wr_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("sb_regs_at_done", dut_regs(), mon_exp);
        chk("ready_low_at_done", wr_ready, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one beat and hold it until an accepting edge (bounded).
  task automatic beat(input logic [W-1:0] d, input logic [2:0] k, input logic [2:0] bl, output bit ok);
    int n;
    din = d; key = k; burst_len = bl; wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 4) begin
      @(posedge Clock); #1;
      n++;
    end
    if (!wr_ready) begin
      chk("ready_timeout", wr_ready, 1);
      wr_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    ok = 1'b1;
    @(posedge Clock); #1;
    wr_valid = 1'b0;
  endtask

  // Full transaction; beat data is d0+i when incr, else d0 then random.
  task automatic txn(input logic [2:0] k, input logic [2:0] bl, input logic [W-1:0] d0,
                     input bit incr, input int gmin, input int gmax);
    logic [2:0]   idx;
    logic [W-1:0] d;
    bit           ok;
    int           g;
    idx = k;
    for (int i = 0; i <= int'(bl); i++) begin
      d = incr ? W'(int'(d0) + i) : ((i == 0) ? d0 : W'($urandom));
      beat(d, k, bl, ok);
      if (!ok) return;
      model_write(idx, d);
      idx = idx + 3'd1;
      if (i == int'(bl)) exp_q.push_back(model_regs());
      chk("regs_after_beat", dut_regs(), model_regs());
      chk("busy_after_beat", busy, 1);
      chk("done_timing", wr_done, (i == int'(bl)) ? 1 : 0);
      if (i < int'(bl)) begin
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
          @(posedge Clock); #1;
          chk("gap_state", state_dbg, BURST);
          chk("gap_regs_hold", dut_regs(), model_regs());
        end
      end
    end
    @(posedge Clock); #1;
    chk("idle_after_done", {busy, wr_ready, wr_done}, 3'b010);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int n;
    model_clear();
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    chk("reset_regs", dut_regs(), 0);
    chk("reset_state", state_dbg, IDLE);
    chk("reset_flags", {busy, wr_ready, wr_done}, 3'b010);

    // Single beat into r3.
    txn(3'd3, 3'd0, 16'hABCD, 1'b0, 0, 0);
    chk("single_r3", r3, 16'hABCD);

    // Wrapping burst 6,7,0,1 with data 1..4, continuous valid.
    model_clear();
    Reset = 1'b1; @(posedge Clock); #1; Reset = 1'b0;
    txn(3'd6, 3'd3, 16'd1, 1'b1, 0, 0);
    chk("wrap_r6", r6, 16'd1);
    chk("wrap_r7", r7, PROT ? 16'd0 : 16'd2);
    chk("wrap_r0", r0, 16'd3);
    chk("wrap_r1", r1, 16'd4);

    // Gapped burst: 3 idle cycles between two beats.
    txn(3'd0, 3'd1, 16'h5A5A, 1'b0, 3, 3);

    // Reset mid-burst after two beats of a 6-beat burst.
    beat(16'h1111, 3'd2, 3'd5, ok);
    beat(16'h2222, 3'd2, 3'd5, ok);
    chk("midburst_busy", busy, 1);
    Reset = 1'b1; @(posedge Clock); #1; Reset = 1'b0;
    model_clear();
    chk("abort_regs", dut_regs(), 0);
    chk("abort_state", state_dbg, IDLE);
    chk("abort_flags", {busy, wr_ready, wr_done}, 3'b010);
    repeat (2) begin
      @(posedge Clock); #1;
      chk("abort_no_done", wr_done, 0);
    end
    txn(3'd5, 3'd0, 16'h0F0F, 1'b0, 0, 0);
    chk("post_abort_r5", r5, 16'h0F0F);

    // r7 direct write, then burst 6,7,0 across r7.
    txn(3'd7, 3'd0, 16'h1234, 1'b0, 0, 0);
    chk("r7_single", r7, PROT ? 16'd0 : 16'h1234);
    txn(3'd6, 3'd2, 16'h0100, 1'b1, 0, 0);
    chk("r7_burst_r6", r6, 16'h0100);
    chk("r7_burst_r7", r7, PROT ? 16'd0 : 16'h0101);
    chk("r7_burst_r0", r0, 16'h0102);

    // Random transactions with random gaps.
    for (int t = 0; t < 40; t++) begin
      txn(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), W'($urandom),
          1'b0, 0, (t % 3 == 0) ? 0 : 2);
    end

    // Drain the scoreboard (bounded).
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_demux_regbank.md
Name: bus_demux_regbank

Overview:
- Write-side counterpart of the 8:1 register read mux in the processor datapath.
- Takes a W-bit bus word plus a 3-bit destination key and steers it into one of eight W-bit holding registers r0..r7.
- Supports single-beat writes and auto-incrementing burst writes that wrap around the register file.
- Sits between the bus/ALU result path and the register bank that feeds the read mux.

Parameters:
- W, 16, data width of the bus and of each register.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- din  in  W  bus data beat.
- key  in  3  destination register index for the first beat; ignored after the first beat of a burst.
- burst_len  in  3  beats minus one (0 = 1 beat, 7 = 8 beats); sampled on the first beat only.
- wr_valid  in  1  a beat is presented on din.
- wr_ready  out  1  block accepts a beat this cycle.
- wr_done  out  1  one-cycle pulse after the last beat of a transaction.
- busy  out  1  high while in BURST or DONE.
- r0..r7  out  W each  holding-register contents.

Behaviour:
- Reset is synchronous, active-high, on Clock.
  - All r0..r7 = 0, state = IDLE, wr_done = 0, busy = 0, wr_ready = 1, internal ptr = 0, remaining = 0.
  - Reset asserted mid-burst aborts the burst. No further writes occur, and wr_done does not pulse for the aborted transaction.
- Handshake:
  - A beat is accepted on a rising edge where wr_valid && wr_ready.
  - din is only sampled on accepting edges.
  - wr_valid may stay high across cycles; each accepting edge consumes one beat.
- FSM states: IDLE, BURST, DONE.
- IDLE (wr_ready = 1, busy = 0):
  - On accept: r[key] <= din at that edge.
  - If burst_len == 0: next state is DONE.
  - Otherwise: ptr <= key+1 (mod 8), remaining <= burst_len-1, next state is BURST.
- BURST (wr_ready = 1, busy = 1):
  - On accept: r[ptr] <= din, ptr <= ptr+1 (mod 8).
  - If remaining == 0: next state is DONE. Otherwise remaining <= remaining-1.
  - With no accept, everything holds. There is no timeout.
- DONE (wr_ready = 0, busy = 1, wr_done = 1): lasts exactly one cycle, then returns to IDLE.
- Write latency: the written register's output shows the new value in the cycle after the accepting edge.
- Throughput:
  - A single-beat transaction occupies 2 cycles.
  - An N-beat burst with continuous wr_valid occupies N+1 cycles.
- Wrap-around: ptr advances from 7 to 0. A burst of 8 writes every register exactly once.
- Only the addressed register changes on an accept; all others hold.
- Registers r0..r7 are driven directly from flops, with no combinational path from din.

Optional Feature:
- Macro: BUS_DEMUX_R7_PROTECT_EN.
- Defined:
  - Any beat targeting r7 (in IDLE via key, or in BURST via ptr) is accepted and counted, but r7 is not updated.
  - r7 holds its value and is still cleared by Reset.
  - wr_done and burst sequencing are unchanged.
- Undefined: r7 is writable like r0..r6.

Decomposition:
- Package bus_demux_pkg holds:
  - the state enum (IDLE, BURST, DONE);
  - constants REG_COUNT = 8 and KEY_W = 3.
- One sub-module, dec3x8: a combinational 3-to-8 one-hot decoder turning the selected index (key or ptr) plus the accept strobe into per-register load enables.

Test Plan:
- Single beat: reset, then key=3, burst_len=0, din=16'hABCD, wr_valid for 1 cycle.
  - Next cycle r3 = ABCD and all other registers = 0.
  - wr_done pulses 1 cycle; wr_ready = 0 that cycle.
- Wrapping burst: key=6, burst_len=3, din = 1, 2, 3, 4 on consecutive cycles with wr_valid held.
  - Result r6=1, r7=2, r0=3, r1=4.
  - wr_done pulses on cycle 5; busy is high from cycle 2 through 5.
- Gapped burst: key=0, burst_len=1, wr_valid dropped for 3 cycles between beats.
  - The FSM stays in BURST, and r1 updates only on the second accept.
  - Exactly one wr_done pulse.
- Reset mid-burst: key=2, burst_len=5, assert Reset after 2 beats.
  - All registers = 0 the next cycle; state IDLE; no wr_done pulse.
  - A fresh single write to r5 then works.
- r7 write:
  - Macro undefined: key=7, din=16'h1234 makes r7 = 1234.
  - Macro defined: r7 stays 0 and wr_done still pulses.
  - Burst key=6, burst_len=2 with the macro defined writes r6 and r0 but skips r7.
